// File: rtl/demux2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes.
// Each destination owns a one-entry output register, so one stalled sink never blocks the other.
module demux2_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int unsigned NUM_DEST = 2;

  logic [NUM_DEST-1:0] slot_valid;
  logic [WIDTH-1:0]    slot_data [NUM_DEST];
  logic [CNT_W-1:0]    slot_cnt  [NUM_DEST];
  logic [NUM_DEST-1:0] out_ready;
  logic                accept;

  assign out_ready = {out1_ready, out0_ready};

  // A slot can take a word when it is empty or being drained this cycle.
  always_comb begin
    in_ready = 1'b0;
    accept   = 1'b0;
    in_ready = !slot_valid[in_sel] || out_ready[in_sel];
    accept   = in_valid && in_ready;
  end

  // Per-destination slot and accept counter; a fill takes priority over a delivery.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NUM_DEST; n++) begin
        slot_valid[n] <= 1'b0;
        slot_data[n]  <= '0;
        slot_cnt[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_DEST; n++) begin
        if (accept && (in_sel == 1'(n))) begin
          slot_valid[n] <= 1'b1;
          slot_data[n]  <= in_data;
          slot_cnt[n]   <= slot_cnt[n] + CNT_W'(1);
        end else if (slot_valid[n] && out_ready[n]) begin
          slot_valid[n] <= 1'b0;
        end
      end
    end
  end

  assign out0_valid = slot_valid[0];
  assign out1_valid = slot_valid[1];
  assign out0_data  = slot_data[0];
  assign out1_data  = slot_data[1];
  assign cnt0       = slot_cnt[0];
  assign cnt1       = slot_cnt[1];

endmodule

// File: tb/tb_demux2_reg.sv
// Bench for demux2_reg: queue-based destination model checked every cycle against
// an 8-bit-counter and a 4-bit-counter instance, plus directed literal checks.
module tb_demux2_reg;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_ready;
  logic             out1_ready;

  logic             a_in_ready, a_out0_valid, a_out1_valid;
  logic [WIDTH-1:0] a_out0_data, a_out1_data;
  logic [7:0]       a_cnt0, a_cnt1;
  logic             b_in_ready, b_out0_valid, b_out1_valid;
  logic [WIDTH-1:0] b_out0_data, b_out1_data;
  logic [3:0]       b_cnt0, b_cnt1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux2_reg #(.WIDTH(WIDTH), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_sel(in_sel),
    .out0_valid(a_out0_valid), .out0_ready(out0_ready), .out0_data(a_out0_data),
    .out1_valid(a_out1_valid), .out1_ready(out1_ready), .out1_data(a_out1_data),
    .cnt0(a_cnt0), .cnt1(a_cnt1)
  );

  demux2_reg #(.WIDTH(WIDTH), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_sel(in_sel),
    .out0_valid(b_out0_valid), .out0_ready(out0_ready), .out0_data(b_out0_data),
    .out1_valid(b_out1_valid), .out1_ready(out1_ready), .out1_data(b_out1_data),
    .cnt0(b_cnt0), .cnt1(b_cnt1)
  );

  // Model: each destination is a FIFO of at most one pending word.
  logic [WIDTH-1:0] pend [2][$];
  logic [WIDTH-1:0] last_word [2];
  int               accepted [2];

  function automatic logic model_ready(input logic sel);
    logic rdy;
    rdy = sel ? out1_ready : out0_ready;
    return (pend[sel].size() == 0) || rdy;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 2; n++) begin
        pend[n].delete();
        last_word[n] = '0;
        accepted[n]  = 0;
      end
    end else begin
      logic take;
      take = in_valid && model_ready(in_sel);
      if (pend[0].size() != 0 && out0_ready) void'(pend[0].pop_front());
      if (pend[1].size() != 0 && out1_ready) void'(pend[1].pop_front());
      if (take) begin
        pend[in_sel].push_back(in_data);
        last_word[in_sel] = in_data;
        accepted[in_sel]  = accepted[in_sel] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic rdy_exp;
    rdy_exp = model_ready(in_sel);
    chk("a_in_ready", 64'(a_in_ready), 64'(rdy_exp));
    chk("b_in_ready", 64'(b_in_ready), 64'(rdy_exp));
    chk("a_out0_valid", 64'(a_out0_valid), 64'(pend[0].size() != 0));
    chk("a_out1_valid", 64'(a_out1_valid), 64'(pend[1].size() != 0));
    chk("b_out0_valid", 64'(b_out0_valid), 64'(pend[0].size() != 0));
    chk("b_out1_valid", 64'(b_out1_valid), 64'(pend[1].size() != 0));
    chk("a_out0_data", 64'(a_out0_data), 64'(last_word[0]));
    chk("a_out1_data", 64'(a_out1_data), 64'(last_word[1]));
    chk("b_out0_data", 64'(b_out0_data), 64'(last_word[0]));
    chk("b_out1_data", 64'(b_out1_data), 64'(last_word[1]));
    chk("a_cnt0", 64'(a_cnt0), 64'(accepted[0] % 256));
    chk("a_cnt1", 64'(a_cnt1), 64'(accepted[1] % 256));
    chk("b_cnt0", 64'(b_cnt0), 64'(accepted[0] % 16));
    chk("b_cnt1", 64'(b_cnt1), 64'(accepted[1] % 16));
  end

  // Drive one cycle of inputs (called just after a rising edge), return just after the next edge.
  task automatic cyc(input logic v, input logic s, input logic [WIDTH-1:0] d,
                     input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Idle after reset.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_out0_valid", 64'(a_out0_valid), 64'd0);
    chk("rst_out1_valid", 64'(a_out1_valid), 64'd0);
    chk("rst_out0_data", 64'(a_out0_data), 64'd0);
    chk("rst_cnt0", 64'(a_cnt0), 64'd0);
    chk("rst_cnt1", 64'(a_cnt1), 64'd0);
    in_sel = 1'b0; #1;
    chk("rst_ready_sel0", 64'(a_in_ready), 64'd1);
    in_sel = 1'b1; #1;
    chk("rst_ready_sel1", 64'(a_in_ready), 64'd1);

    // Single word to destination 0, one cycle latency.
    cyc(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("one_out0_valid", 64'(a_out0_valid), 64'd1);
    chk("one_out0_data", 64'(a_out0_data), 64'hDEADBEEF);
    chk("one_cnt0", 64'(a_cnt0), 64'd1);
    chk("one_out1_valid", 64'(a_out1_valid), 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("one_drained", 64'(a_out0_valid), 64'd0);

    // Stall slot 0, destination 1 still flows.
    cyc(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h33; #1;
    chk("stall_ready_sel0", 64'(a_in_ready), 64'd0);
    in_sel = 1'b1; in_data = 32'h22; #1;
    chk("stall_ready_sel1", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    chk("stall_out1_data", 64'(a_out1_data), 64'h22);
    chk("stall_out1_valid", 64'(a_out1_valid), 64'd1);
    cyc(1'b1, 1'b0, 32'h44, 1'b0, 1'b1);
    chk("stall_out1_gone", 64'(a_out1_valid), 64'd0);
    chk("stall_out0_hold", 64'(a_out0_data), 64'h11);
    chk("stall_cnt0", 64'(a_cnt0), 64'd2);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("stall_released", 64'(a_out0_valid), 64'd0);

    // Ten back-to-back alternating words.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_sel = 1'(i % 2); in_data = 32'h100 + 32'(i);
      out0_ready = 1'b1; out1_ready = 1'b1; #1;
      chk("b2b_in_ready", 64'(a_in_ready), 64'd1);
      @(posedge clk); #1;
    end
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("b2b_cnt0", 64'(a_cnt0), 64'd5);
    chk("b2b_cnt1", 64'(a_cnt1), 64'd5);
    chk("b2b_last0", 64'(a_out0_data), 64'h108);
    chk("b2b_last1", 64'(a_out1_data), 64'h109);

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("wrap_b_cnt1", 64'(b_cnt1), 64'd1);
    chk("wrap_b_cnt0", 64'(b_cnt0), 64'd0);
    chk("wrap_a_cnt1", 64'(a_cnt1), 64'd17);

    // Mixed pattern of valids and back-pressure.
    for (int i = 0; i < 24; i++)
      cyc(1'((i % 5) != 4), 1'((i ^ (i >> 2)) & 1), 32'h300 + 32'(i),
          1'((i % 3) != 0), 1'((i % 4) != 1));

    // Asynchronous reset while slot 0 is full and stalled.
    cyc(1'b1, 1'b0, 32'h55, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(a_out0_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_out0_valid", 64'(a_out0_valid), 64'd0);
    chk("async_cnt0", 64'(a_cnt0), 64'd0);
    chk("async_b_out0_valid", 64'(b_out0_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    in_sel = 1'b0; #1;
    chk("post_rst_ready", 64'(a_in_ready), 64'd1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
